// File: rtl/top_majority41.sv
// 41-input majority voter with a registered output.
// Popcount via a balanced adder tree, then threshold compare.
module top_majority41 (
    input  logic clk,
    input  logic rst,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic x5,
    input  logic x6,
    input  logic x7,
    input  logic x8,
    input  logic x9,
    input  logic x10,
    input  logic x11,
    input  logic x12,
    input  logic x13,
    input  logic x14,
    input  logic x15,
    input  logic x16,
    input  logic x17,
    input  logic x18,
    input  logic x19,
    input  logic x20,
    input  logic x21,
    input  logic x22,
    input  logic x23,
    input  logic x24,
    input  logic x25,
    input  logic x26,
    input  logic x27,
    input  logic x28,
    input  logic x29,
    input  logic x30,
    input  logic x31,
    input  logic x32,
    input  logic x33,
    input  logic x34,
    input  logic x35,
    input  logic x36,
    input  logic x37,
    input  logic x38,
    input  logic x39,
    input  logic x40,
    output logic y0
);

    logic [40:0] x;
    logic [5:0]  l1 [21];
    logic [5:0]  l2 [11];
    logic [5:0]  l3 [6];
    logic [5:0]  l4 [3];
    logic [5:0]  w;
    logic        y0_d;
    logic        y0_q;

    assign x = {x40, x39, x38, x37, x36, x35, x34, x33, x32, x31,
                x30, x29, x28, x27, x26, x25, x24, x23, x22, x21,
                x20, x19, x18, x17, x16, x15, x14, x13, x12, x11,
                x10, x9,  x8,  x7,  x6,  x5,  x4,  x3,  x2,  x1,
                x0};

    // Balanced pairwise reduction: 41 -> 21 -> 11 -> 6 -> 3 -> 1.
    // The odd element at each level passes through unchanged.
    always_comb begin
        for (int i = 0; i < 20; i++) begin
            l1[i] = {5'd0, x[2*i]} + {5'd0, x[2*i+1]};
        end
        l1[20] = {5'd0, x[40]};
        for (int i = 0; i < 10; i++) begin
            l2[i] = l1[2*i] + l1[2*i+1];
        end
        l2[10] = l1[20];
        for (int i = 0; i < 5; i++) begin
            l3[i] = l2[2*i] + l2[2*i+1];
        end
        l3[5] = l2[10];
        for (int i = 0; i < 3; i++) begin
            l4[i] = l3[2*i] + l3[2*i+1];
        end
        w = (l4[0] + l4[1]) + l4[2];
    end

    // Majority threshold: 21 of 41 inputs high.
    always_comb begin
        y0_d = 1'b0;
        if (w >= 6'd21) begin
            y0_d = 1'b1;
        end
    end

    // Output register, synchronous reset has priority over data.
    always_ff @(posedge clk) begin
        if (rst) begin
            y0_q <= 1'b0;
        end else begin
            y0_q <= y0_d;
        end
    end

    assign y0 = y0_q;

endmodule

// File: tb/tb_top_majority41.sv
// Scoreboard bench for top_majority41.
// Driver queues expected y0 per cycle; monitor checks after each edge.
module tb_top_majority41;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [40:0] xv = '0;
    logic        y0;

    int   checks = 0;
    int   errors = 0;
    logic exp_q [$];

    always #5 clk = ~clk;

    top_majority41 dut (
        .clk(clk), .rst(rst),
        .x0(xv[0]),   .x1(xv[1]),   .x2(xv[2]),   .x3(xv[3]),
        .x4(xv[4]),   .x5(xv[5]),   .x6(xv[6]),   .x7(xv[7]),
        .x8(xv[8]),   .x9(xv[9]),   .x10(xv[10]), .x11(xv[11]),
        .x12(xv[12]), .x13(xv[13]), .x14(xv[14]), .x15(xv[15]),
        .x16(xv[16]), .x17(xv[17]), .x18(xv[18]), .x19(xv[19]),
        .x20(xv[20]), .x21(xv[21]), .x22(xv[22]), .x23(xv[23]),
        .x24(xv[24]), .x25(xv[25]), .x26(xv[26]), .x27(xv[27]),
        .x28(xv[28]), .x29(xv[29]), .x30(xv[30]), .x31(xv[31]),
        .x32(xv[32]), .x33(xv[33]), .x34(xv[34]), .x35(xv[35]),
        .x36(xv[36]), .x37(xv[37]), .x38(xv[38]), .x39(xv[39]),
        .x40(xv[40]),
        .y0(y0)
    );

    // Monitor: one expected value per clock edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            checks++;
            if (y0 !== e) begin
                errors++;
                $display("FAIL y0 check %0d: got %b want %b",
                         checks, y0, e);
            end
        end
    end

    task automatic apply(input logic [40:0] v, input logic r,
                         input logic e, input bit glitch);
        @(negedge clk);
        xv = v;
        rst = r;
        exp_q.push_back(e);
        if (glitch) begin
            #2 xv = ~v;
            #2 xv = v;
        end
    endtask

    localparam logic [40:0] ALL1  = {41{1'b1}};
    localparam logic [40:0] ALL0  = '0;
    localparam logic [40:0] LO20  = 41'h000_000F_FFFF;
    localparam logic [40:0] LO21  = 41'h000_001F_FFFF;
    localparam logic [40:0] HI21  = ~41'h000_000F_FFFF;
    localparam logic [40:0] HI20  = ~41'h000_001F_FFFF;
    localparam logic [40:0] W30   = 41'h000_3FFF_FFFF;

    initial begin
        logic [40:0] v;
        logic [40:0] m;
        // reset with all inputs high
        apply(ALL1, 1'b1, 1'b0, 1'b0);
        apply(ALL1, 1'b1, 1'b0, 1'b0);
        apply(ALL1, 1'b0, 1'b1, 1'b0);
        // extremes
        apply(ALL0, 1'b0, 1'b0, 1'b0);
        apply(ALL1, 1'b0, 1'b1, 1'b0);
        // threshold boundary
        apply(LO20, 1'b0, 1'b0, 1'b0);
        apply(LO21, 1'b0, 1'b1, 1'b0);
        apply(HI21, 1'b0, 1'b1, 1'b0);
        apply(HI20, 1'b0, 1'b0, 1'b0);
        // alternate 20/21 with mid-cycle glitches
        for (int i = 0; i < 8; i++) begin
            apply(LO20, 1'b0, 1'b0, 1'b1);
            apply(LO21, 1'b0, 1'b1, 1'b1);
        end
        // reset mid-stream
        apply(W30, 1'b0, 1'b1, 1'b0);
        apply(W30, 1'b1, 1'b0, 1'b0);
        apply(W30, 1'b0, 1'b1, 1'b0);
        // one-hot (W=1) and one-cold (W=40)
        for (int i = 0; i < 41; i++) begin
            m = 41'd1;
            m = m << i;
            apply(m, 1'b0, 1'b0, 1'b0);
            apply(~m, 1'b0, 1'b1, 1'b0);
        end
        // random vectors with varied density
        for (int i = 0; i < 4000; i++) begin
            v = {$urandom(), $urandom()};
            case (i % 4)
                1: v = v & {$urandom(), $urandom()};
                2: v = v | {$urandom(), $urandom()};
                default: ;
            endcase
            apply(v, 1'b0, ($countones(v) >= 21), 1'b0);
        end
        // drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
